// File: rtl/sram2rw_pkg.sv
// Shared definitions for the SRAM2RW16x4-backed FIFO controller.
//   SRAM_DEPTH / SRAM_WIDTH : geometry of the dual-port macro
//   PIN_IDLE                : inactive level of the macro's CSB/WEB/OEB pins
package sram2rw_pkg;

  localparam int   SRAM_DEPTH = 16;
  localparam int   SRAM_WIDTH = 4;
  localparam logic PIN_IDLE   = 1'b1;

endpackage

// File: rtl/sram2rw_fifo_outbuf.sv
// Two-entry output buffer sitting behind the SRAM read port.
// It absorbs the read data that the consumer does not take on the cycle it
// arrives, so reads can be issued ahead and one dequeue per cycle is kept.
//   clock, reset_n : clock, async active-low reset
//   push/push_data : store one word at the tail
//   pop            : drop the head word
//   occ            : number of held words (0..2)
//   head           : oldest held word (meaningful when occ != 0)
module sram2rw_fifo_outbuf
  import sram2rw_pkg::*;
#(
  parameter int WIDTH = SRAM_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]       occ_q, occ_d;

  // ent0 is always the head; a pop shifts ent1 down.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = push_data;
        else               ent1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // pop is only asserted with occ != 0, so occ is 1 or 2 here
        if (occ_q == 2'd1) begin
          ent0_d = push_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = ent0_q;

endmodule

// File: rtl/sram2rw_fifo_ctrl.sv
// FIFO controller driving an SRAM2RW16x4 dual-port macro: port 1 writes,
// port 2 reads (registered, one-cycle latency). Presents valid/ready
// enqueue and dequeue streams; a two-entry output buffer hides the read
// latency.
//   clock, reset_n                         : clock, async active-low reset
//   enq_valid/enq_ready/enq_data           : producer stream
//   deq_valid/deq_ready/deq_data           : consumer stream
//   count                                  : total words held (SRAM + buffer + in flight)
//   sram_a1/i1/csb1/web1/oeb1              : macro port 1 (write)
//   sram_a2/csb2/web2/oeb2, sram_o2        : macro port 2 (read)
module sram2rw_fifo_ctrl
  import sram2rw_pkg::*;
#(
  parameter int DEPTH  = SRAM_DEPTH,
  parameter int WIDTH  = SRAM_WIDTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 3)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [WIDTH-1:0]  enq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [WIDTH-1:0]  deq_data,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] sram_a1,
  output logic [WIDTH-1:0]  sram_i1,
  output logic              sram_csb1,
  output logic              sram_web1,
  output logic              sram_oeb1,
  output logic [ADDR_W-1:0] sram_a2,
  output logic              sram_csb2,
  output logic              sram_web2,
  output logic              sram_oeb2,
  input  logic [WIDTH-1:0]  sram_o2
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]  sram_cnt;
  logic             inflight_q, inflight_d;
  logic             enq_fire, deq_fire, rd_issue;
  logic             buf_push, buf_pop;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head;
  logic [2:0]       pend;

  // Pointers carry one extra bit so full (DEPTH) and empty (0) differ.
  assign sram_cnt = wr_ptr_q - rd_ptr_q;

  // Gated by reset_n so the producer sees not-ready while reset is held.
  assign enq_ready = reset_n & (sram_cnt != FULL_CNT);
  assign enq_fire  = enq_valid & enq_ready;

  assign deq_valid = (occ != 2'd0) | inflight_q;
  assign deq_fire  = deq_valid & deq_ready;

  // Issue only if the word will have a buffer slot when it returns.
  assign pend     = {1'b0, occ} + {2'b00, inflight_q};
  assign rd_issue = (sram_cnt != '0) & (pend < (3'd2 + {2'b00, deq_fire}));

  // Returning read data bypasses the buffer when the consumer takes it at once.
  assign buf_pop  = deq_fire & (occ != 2'd0);
  assign buf_push = inflight_q & ~(deq_fire & (occ == 2'd0));

  sram2rw_fifo_outbuf #(.WIDTH(WIDTH)) u_outbuf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (buf_push),
    .push_data (sram_o2),
    .pop       (buf_pop),
    .occ       (occ),
    .head      (head)
  );

  always_comb begin
    if (occ != 2'd0)     deq_data = head;
    else if (inflight_q) deq_data = sram_o2;
    else                 deq_data = '0;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{ADDR_W{1'b0}}, enq_fire};
    rd_ptr_d   = rd_ptr_q + {{ADDR_W{1'b0}}, rd_issue};
    inflight_d = rd_issue;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  assign count = CNT_W'(sram_cnt) + CNT_W'(occ) + CNT_W'(inflight_q);

  always_comb begin
    sram_csb1 = PIN_IDLE;
    sram_web1 = PIN_IDLE;
    sram_oeb1 = PIN_IDLE;
    sram_a1   = '0;
    sram_i1   = '0;
    if (enq_fire) begin
      sram_csb1 = ~PIN_IDLE;
      sram_web1 = ~PIN_IDLE;
      sram_a1   = wr_ptr_q[ADDR_W-1:0];
      sram_i1   = enq_data;
    end
  end

  always_comb begin
    sram_csb2 = PIN_IDLE;
    sram_web2 = PIN_IDLE;
    sram_oeb2 = PIN_IDLE;
    sram_a2   = '0;
    if (rd_issue) begin
      sram_csb2 = ~PIN_IDLE;
      sram_oeb2 = ~PIN_IDLE;
      sram_a2   = rd_ptr_q[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_sram2rw_fifo_ctrl.sv
module tb_sram2rw_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enq_valid, enq_ready;
  logic [3:0] enq_data;
  logic       deq_valid, deq_ready;
  logic [3:0] deq_data;
  logic [4:0] count;
  logic [3:0] sram_a1, sram_i1, sram_a2;
  logic       sram_csb1, sram_web1, sram_oeb1;
  logic       sram_csb2, sram_web2, sram_oeb2;
  logic [3:0] sram_o2 = 4'h9;
  logic [3:0] mem [16];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sram2rw_fifo_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .count     (count),
    .sram_a1   (sram_a1),
    .sram_i1   (sram_i1),
    .sram_csb1 (sram_csb1),
    .sram_web1 (sram_web1),
    .sram_oeb1 (sram_oeb1),
    .sram_a2   (sram_a2),
    .sram_csb2 (sram_csb2),
    .sram_web2 (sram_web2),
    .sram_oeb2 (sram_oeb2),
    .sram_o2   (sram_o2)
  );

  // Behavioural SRAM2RW16x4: synchronous write on port 1, registered read on port 2.
  always @(posedge clock) begin
    if (!sram_csb1 && !sram_web1) mem[sram_a1] <= sram_i1;
    if (!sram_csb2 && !sram_oeb2) sram_o2 <= mem[sram_a2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a queue of held words tagged with the cycle they were accepted.
  // A word is dequeue-visible two cycles after acceptance, strictly in order.
  typedef struct {
    logic [3:0] d;
    int         c;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   wr_tot = 0, rd_tot = 0, deq_tot = 0;
  bit   m_acc, m_dq, m_rd, m_v;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("rst_pins", {enq_ready, deq_valid, sram_csb1, sram_web1, sram_oeb1,
                         sram_csb2, sram_web2, sram_oeb2}, 8'b0011_1111);
        chk("rst_count", count, 0);
        q.delete();
        wr_tot = 0; rd_tot = 0; deq_tot = 0;
      end else begin
        m_acc = enq_valid && enq_ready;
        m_dq  = deq_valid && deq_ready;
        m_rd  = !sram_csb2;
        m_v   = (q.size() > 0) && (q[0].c <= cyc - 2);
        chk("deq_valid", deq_valid, m_v);
        if (m_v) chk("deq_data", deq_data, q[0].d);
        chk("count", count, q.size());
        if (q.size() < 16)  chk("enq_ready_room", enq_ready, 1);
        if (q.size() == 18) chk("enq_ready_full", enq_ready, 0);
        chk("wr_pins", {sram_csb1, sram_web1, sram_oeb1, sram_a1, sram_i1},
            m_acc ? {3'b001, 4'(wr_tot), enq_data} : {3'b111, 8'h00});
        chk("rd_pins", {sram_web2, sram_oeb2, sram_a2},
            m_rd ? {2'b10, 4'(rd_tot)} : {2'b11, 4'h0});
        if (m_rd) chk("rd_nonempty", rd_tot < wr_tot, 1);
        if (m_acc) begin
          q.push_back('{d: enq_data, c: cyc});
          wr_tot++;
        end
        if (m_dq) begin
          if (q.size() > 0) void'(q.pop_front());
          deq_tot++;
        end
        if (m_rd) rd_tot++;
        chk("rd_window", (rd_tot - deq_tot) <= 2, 1);
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    #1;
    while (count != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", count, 0);
  endtask

  int d0;

  initial begin
    reset_n = 1'b0; enq_valid = 1'b0; enq_data = 4'h0; deq_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("t0_post_rst", {enq_ready, deq_valid, deq_data, count}, {2'b10, 4'h0, 5'd0});

    // single word latency
    tick();
    enq_valid = 1'b1; enq_data = 4'h5;
    #1 chk("t1_wr_pins", {sram_csb1, sram_web1, sram_a1}, 6'b00_0000);
    chk("t1_c0_count", count, 0);
    tick();
    enq_valid = 1'b0;
    #1 chk("t1_c1", {count, deq_valid, sram_csb2}, {5'd1, 2'b00});
    tick();
    chk("t1_c2", {count, deq_valid, deq_data}, {5'd1, 1'b1, 4'h5});
    tick();
    chk("t1_c3_count", count, 1);
    deq_ready = 1'b1;
    tick();
    chk("t1_c4", {count, deq_valid}, {5'd0, 1'b0});
    deq_ready = 1'b0;

    // fill to capacity, then drain in order
    enq_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      enq_data = 4'(i);
      #1 chk("t2_fill_rdy", enq_ready, 1);
      tick();
    end
    enq_data = 4'h7;
    #1 chk("t2_full", {enq_ready, count}, {1'b0, 5'd18});
    tick();
    chk("t2_hold_count", count, 18);
    enq_valid = 1'b0; deq_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      #1 chk("t2_drain", {deq_valid, deq_data}, {1'b1, 4'(i)});
      tick();
    end
    #1 chk("t2_empty", {count, deq_valid}, {5'd0, 1'b0});

    // streaming, pointers wrap
    enq_valid = 1'b1; deq_ready = 1'b1;
    d0 = deq_tot;
    for (int i = 0; i < 40; i++) begin
      enq_data = 4'(i * 3 + 1);
      tick();
    end
    chk("t3_tput", deq_tot - d0, 38);
    chk("t3_count", count, 2);
    drain(20);

    // random consumer stalls
    for (int i = 0; i < 200; i++) begin
      enq_valid = ($urandom_range(0, 3) != 0);
      enq_data  = 4'($urandom);
      deq_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain(40);

    // full with simultaneous enqueue and dequeue
    enq_valid = 1'b1; deq_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      enq_data = 4'(15 - i);
      tick();
    end
    chk("t5_full", {count, enq_ready}, {5'd18, 1'b0});
    deq_ready = 1'b1; enq_data = 4'h3;
    d0 = deq_tot;
    #1 chk("t5_f0_rdy", enq_ready, 0);
    tick();
    chk("t5_f1", {enq_ready, count}, {1'b1, 5'd17});
    for (int i = 0; i < 10; i++) begin
      enq_data = 4'(i + 8);
      tick();
    end
    chk("t5_tput", deq_tot - d0, 11);
    chk("t5_count", count, 17);
    drain(40);

    // asynchronous reset mid-stream
    enq_valid = 1'b1; deq_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      enq_data = 4'(i + 2);
      tick();
    end
    chk("t6_pre_count", count, 10);
    #2 reset_n = 1'b0;
    #1 chk("t6_in_rst", {enq_ready, deq_valid, sram_csb1, sram_web1, sram_oeb1,
                         sram_csb2, sram_web2, sram_oeb2, deq_data, count},
           {8'b0011_1111, 4'h0, 5'd0});
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1; enq_valid = 1'b0;
    #1 chk("t6_post", {enq_ready, deq_valid, deq_data, count}, {2'b10, 4'h0, 5'd0});
    tick();
    enq_valid = 1'b1; enq_data = 4'hA; deq_ready = 1'b1;
    tick();
    enq_valid = 1'b0;
    tick();
    chk("t6_deq", {deq_valid, deq_data}, {1'b1, 4'hA});
    tick();
    chk("t6_empty", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before test end");
    $fatal(1);
  end

endmodule
